l1_bus_arbiter: RTL

- Shares the single TileLink-UL style A/D channel pair between the L1 instruction-cache bus handler (I) and the L1 data-cache bus handler (D).
- Grants the A channel to one requester at a time and holds the grant until every outstanding beat of that requester has been acknowledged.
- Routes D-channel beats back to their owner by dBitsSource.
- Sits between both caches' bus-hand logic and the system crossbar.

---
 rtl/l1_bus_arbiter_pkg.sv | 33 +++
 rtl/l1_bus_arbiter_if.sv | 76 +++++++
 rtl/l1_arb_rr_pick.sv | 18 +
 rtl/l1_bus_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/l1_bus_arbiter_pkg.sv
// rtl/l1_bus_arbiter_pkg.sv - shared opcodes, source IDs and state types for the L1 bus arbiter
package l1_bus_arbiter_pkg;

   // TileLink-UL A-channel opcodes issued by the caches
   localparam logic [2:0] OP_PUT     = 3'd0;
   localparam logic [2:0] OP_GET     = 3'd4;

   // TileLink-UL D-channel opcodes returned by the crossbar
   localparam logic [2:0] OP_ACK     = 3'd0;
   localparam logic [2:0] OP_ACKDATA = 3'd1;

   // Source IDs stamped on A beats and used to route D beats back
   localparam logic [4:0] SRC_I_ID   = 5'd0;
   localparam logic [4:0] SRC_D_ID   = 5'd1;

   // Outstanding-beat window per grant
   localparam int         MAX_OUT_DEF = 8;

   // Every beat is one 32-bit word
   localparam logic [3:0] A_SIZE     = 4'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_e;

endpackage

// File: rtl/l1_bus_arbiter_if.sv
// rtl/l1_bus_arbiter_if.sv - cache-side and crossbar-side A/D channel bundle for the L1 bus arbiter
interface l1_bus_arbiter_if;

   // I-cache bus handler
   logic        I_aValid;
   logic        I_aReady;
   logic [31:0] I_aAddress;
   logic [2:0]  I_aOpcode;
   logic [3:0]  I_aMask;
   logic [31:0] I_aData;
   logic        I_dValid;
   logic        I_dReady;
   logic [2:0]  I_dOpcode;
   logic [31:0] I_dData;

   // D-cache bus handler
   logic        D_aValid;
   logic        D_aReady;
   logic [31:0] D_aAddress;
   logic [2:0]  D_aOpcode;
   logic [3:0]  D_aMask;
   logic [31:0] D_aData;
   logic        D_dValid;
   logic        D_dReady;
   logic [2:0]  D_dOpcode;
   logic [31:0] D_dData;

   // System crossbar
   logic        Bus_aBitsValid;
   logic        Bus_aBitsReady;
   logic [31:0] Bus_aBitsAddress;
   logic [2:0]  Bus_aBitsOpcode;
   logic [3:0]  Bus_aBitsMask;
   logic [31:0] Bus_aBitsData;
   logic [4:0]  Bus_aBitsSource;
   logic [3:0]  Bus_aBitsSize;
   logic [2:0]  Bus_aBitsParam;
   logic        Bus_aBitsCorrupt;
   logic        Bus_dBitsValid;
   logic        Bus_dBitsReady;
   logic [2:0]  Bus_dBitsOpcode;
   logic [31:0] Bus_dBitsData;
   logic [4:0]  Bus_dBitsSource;

   // Sticky routing error flag
   logic        Arb_SrcErr;

   // Arbiter view
   modport slave (
      input  I_aValid, I_aAddress, I_aOpcode, I_aMask, I_aData, I_dReady,
      output I_aReady, I_dValid, I_dOpcode, I_dData,
      input  D_aValid, D_aAddress, D_aOpcode, D_aMask, D_aData, D_dReady,
      output D_aReady, D_dValid, D_dOpcode, D_dData,
      output Bus_aBitsValid, Bus_aBitsAddress, Bus_aBitsOpcode, Bus_aBitsMask,
      output Bus_aBitsData, Bus_aBitsSource, Bus_aBitsSize, Bus_aBitsParam, Bus_aBitsCorrupt,
      input  Bus_aBitsReady,
      input  Bus_dBitsValid, Bus_dBitsOpcode, Bus_dBitsData, Bus_dBitsSource,
      output Bus_dBitsReady,
      output Arb_SrcErr
   );

   // Surroundings view: caches and crossbar together
   modport master (
      output I_aValid, I_aAddress, I_aOpcode, I_aMask, I_aData, I_dReady,
      input  I_aReady, I_dValid, I_dOpcode, I_dData,
      output D_aValid, D_aAddress, D_aOpcode, D_aMask, D_aData, D_dReady,
      input  D_aReady, D_dValid, D_dOpcode, D_dData,
      input  Bus_aBitsValid, Bus_aBitsAddress, Bus_aBitsOpcode, Bus_aBitsMask,
      input  Bus_aBitsData, Bus_aBitsSource, Bus_aBitsSize, Bus_aBitsParam, Bus_aBitsCorrupt,
      output Bus_aBitsReady,
      output Bus_dBitsValid, Bus_dBitsOpcode, Bus_dBitsData, Bus_dBitsSource,
      input  Bus_dBitsReady,
      input  Arb_SrcErr
   );

endinterface

// File: rtl/l1_arb_rr_pick.sv
// rtl/l1_arb_rr_pick.sv - two-way round-robin picker producing a one-hot grant
module l1_arb_rr_pick
   import l1_bus_arbiter_pkg::*;
(
   input  logic [1:0] req_i,    // bit 0 = I-cache, bit 1 = D-cache
   input  req_e       last_i,   // requester granted most recently
   output logic [1:0] gnt_o     // one-hot, same bit order as req_i
);

   // A lone requester wins outright; on a tie the one not granted last time wins.
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = (last_i == REQ_I) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/l1_bus_arbiter.sv
// rtl/l1_bus_arbiter.sv - shares one TileLink-UL A/D channel pair between the L1 I- and D-cache bus handlers
module l1_bus_arbiter
   import l1_bus_arbiter_pkg::*;
#(
   parameter logic [4:0] SRC_I   = SRC_I_ID,
   parameter logic [4:0] SRC_D   = SRC_D_ID,
   parameter int         MAX_OUT = MAX_OUT_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   l1_bus_arbiter_if.slave arb
);

   localparam int               CNT_W   = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   arb_state_e       state_q;
   req_e             last_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             src_err_q;

   logic             in_i;
   logic             in_d;
   logic             room;
   logic             hit_i;
   logic             hit_d;
   logic             a_fire;
   logic             d_fire;
   logic             d_own;
   logic [1:0]       pick;

   assign in_i  = (state_q == ST_GRANT_I);
   assign in_d  = (state_q == ST_GRANT_D);
   assign room  = (cnt_q < CNT_MAX);
   assign hit_i = (arb.Bus_dBitsSource == SRC_I);
   assign hit_d = (arb.Bus_dBitsSource == SRC_D);

   l1_arb_rr_pick u_pick (
      .req_i  ({arb.D_aValid, arb.I_aValid}),
      .last_i (last_q),
      .gnt_o  (pick)
   );

   // A channel: forward only the granted requester, and only while the window has room.
   always_comb begin
      arb.Bus_aBitsValid   = 1'b0;
      arb.Bus_aBitsAddress = '0;
      arb.Bus_aBitsOpcode  = '0;
      arb.Bus_aBitsMask    = '0;
      arb.Bus_aBitsData    = '0;
      arb.Bus_aBitsSource  = '0;
      arb.I_aReady         = 1'b0;
      arb.D_aReady         = 1'b0;
      case (state_q)
         ST_GRANT_I: begin
            arb.Bus_aBitsValid   = arb.I_aValid && room;
            arb.Bus_aBitsAddress = arb.I_aAddress;
            arb.Bus_aBitsOpcode  = arb.I_aOpcode;
            arb.Bus_aBitsMask    = arb.I_aMask;
            arb.Bus_aBitsData    = arb.I_aData;
            arb.Bus_aBitsSource  = SRC_I;
            arb.I_aReady         = arb.Bus_aBitsReady && room;
         end
         ST_GRANT_D: begin
            arb.Bus_aBitsValid   = arb.D_aValid && room;
            arb.Bus_aBitsAddress = arb.D_aAddress;
            arb.Bus_aBitsOpcode  = arb.D_aOpcode;
            arb.Bus_aBitsMask    = arb.D_aMask;
            arb.Bus_aBitsData    = arb.D_aData;
            arb.Bus_aBitsSource  = SRC_D;
            arb.D_aReady         = arb.Bus_aBitsReady && room;
         end
         default: ;
      endcase
   end

   assign arb.Bus_aBitsSize    = A_SIZE;
   assign arb.Bus_aBitsParam   = 3'd0;
   assign arb.Bus_aBitsCorrupt = 1'b0;

   // D channel: route by source regardless of grant; unknown sources are swallowed.
   // Everything is held at zero while reset is asserted so outputs clear immediately.
   always_comb begin
      arb.I_dValid       = 1'b0;
      arb.D_dValid       = 1'b0;
      arb.I_dOpcode      = '0;
      arb.D_dOpcode      = '0;
      arb.I_dData        = '0;
      arb.D_dData        = '0;
      arb.Bus_dBitsReady = 1'b0;
      if (rst_n) begin
         arb.I_dOpcode = arb.Bus_dBitsOpcode;
         arb.D_dOpcode = arb.Bus_dBitsOpcode;
         arb.I_dData   = arb.Bus_dBitsData;
         arb.D_dData   = arb.Bus_dBitsData;
         if (hit_i) begin
            arb.I_dValid       = arb.Bus_dBitsValid;
            arb.Bus_dBitsReady = arb.I_dReady;
         end else if (hit_d) begin
            arb.D_dValid       = arb.Bus_dBitsValid;
            arb.Bus_dBitsReady = arb.D_dReady;
         end else begin
            arb.Bus_dBitsReady = 1'b1;
         end
      end
   end

   assign a_fire = arb.Bus_aBitsValid && arb.Bus_aBitsReady;
   assign d_fire = arb.Bus_dBitsValid && arb.Bus_dBitsReady;
   assign d_own  = d_fire && ((in_i && hit_i) || (in_d && hit_d));

   // Outstanding window: an issue and a retirement in the same cycle cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (a_fire && !d_own) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (d_own && !a_fire && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Grant FSM: arbitrate from IDLE, hold the grant until the owner is idle and fully acknowledged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= REQ_I;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (pick[0]) begin
                  state_q <= ST_GRANT_I;
                  last_q  <= REQ_I;
               end else if (pick[1]) begin
                  state_q <= ST_GRANT_D;
                  last_q  <= REQ_D;
               end
            end
            ST_GRANT_I: begin
               if (!arb.I_aValid && (cnt_q == '0)) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GRANT_D: begin
               if (!arb.D_aValid && (cnt_q == '0)) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Sticky flag for any D beat carrying a source we never issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_err_q <= 1'b0;
      end else if (arb.Bus_dBitsValid && !hit_i && !hit_d) begin
         src_err_q <= 1'b1;
      end
   end

   assign arb.Arb_SrcErr = src_err_q;

endmodule
